// File: rtl/w_scheduler_pkg.sv
// Shared constants, state encodings and arithmetic helpers for the SHA-2
// message-schedule expander.
package w_scheduler_pkg;

  localparam int BLOCK512_WORDS  = 64;
  localparam int BLOCK1024_WORDS = 80;
  localparam int MSG_WORDS       = 16;

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  // Small sigma rotation/shift amounts, SHA-224/256 family
  localparam int S0_256_ROT_A = 7;
  localparam int S0_256_ROT_B = 18;
  localparam int S0_256_SHR   = 3;
  localparam int S1_256_ROT_A = 17;
  localparam int S1_256_ROT_B = 19;
  localparam int S1_256_SHR   = 10;

  // Small sigma rotation/shift amounts, SHA-384/512 family
  localparam int S0_512_ROT_A = 1;
  localparam int S0_512_ROT_B = 8;
  localparam int S0_512_SHR   = 7;
  localparam int S1_512_ROT_A = 19;
  localparam int S1_512_ROT_B = 61;
  localparam int S1_512_SHR   = 6;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Four-operand modular add; 32-bit mode drops carries out of bit 31.
  function automatic logic [63:0] madd_32_64(input logic mode64,
                                             input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [63:0] c,
                                             input logic [63:0] d);
    logic [63:0] sum;
    sum = a + b + c + d;
    return mode64 ? sum : {32'h0, sum[31:0]};
  endfunction

endpackage

// File: rtl/w_scheduler_small_sigma.sv
// Combinational SHA-2 small sigma: sel=0 gives s0, sel=1 gives s1, for either
// the 32-bit or the 64-bit word family.
module w_scheduler_small_sigma
  import w_scheduler_pkg::*;
(
  input  logic        mode64,
  input  logic        sel,
  input  logic [63:0] data,
  output logic [63:0] result
);

  logic [31:0] d32;
  logic [31:0] s0_32;
  logic [31:0] s1_32;
  logic [63:0] s0_64;
  logic [63:0] s1_64;

  always_comb begin
    d32   = data[31:0];
    s0_32 = rotr32(d32, S0_256_ROT_A) ^ rotr32(d32, S0_256_ROT_B) ^ (d32 >> S0_256_SHR);
    s1_32 = rotr32(d32, S1_256_ROT_A) ^ rotr32(d32, S1_256_ROT_B) ^ (d32 >> S1_256_SHR);
    s0_64 = rotr64(data, S0_512_ROT_A) ^ rotr64(data, S0_512_ROT_B) ^ (data >> S0_512_SHR);
    s1_64 = rotr64(data, S1_512_ROT_A) ^ rotr64(data, S1_512_ROT_B) ^ (data >> S1_512_SHR);
    result = '0;
    if (mode64) begin
      result = sel ? s1_64 : s0_64;
    end else begin
      result = {32'h0, (sel ? s1_32 : s0_32)};
    end
  end

endmodule

// File: rtl/w_scheduler.sv
// SHA-2 message-schedule expander: passes the 16 message words straight through
// to the HCU, then generates W16..W(R-1) from a 16-word sliding window.
module w_scheduler
  import w_scheduler_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH = 64,
  parameter int M_AXIS_DATA_WIDTH = 64
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [1:0]                   sha_type,
  input  logic                         en,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         proto_err
);

  // Handshakes: a word moves on a port in a cycle where both tvalid and tready
  // are high at the rising edge. In LOAD the input and output handshakes are
  // the same event (pass-through); in EXPAND only the output side moves.

  logic [0:0]  state;
  logic [6:0]  t;
  logic        mode64;
  logic [63:0] win [MSG_WORDS];

  logic        go;
  logic        mode_eff;
  logic [6:0]  last_t;
  logic [63:0] in_word;
  logic [63:0] s0_out;
  logic [63:0] s1_out;
  logic [63:0] expand_word;
  logic [63:0] shift_word;
  logic        hs_in;
  logic        hs_exp;
  logic        unused_sha_type;

  assign unused_sha_type = sha_type[0];

  // en only gates the first word of a block; a started block always finishes.
  assign go       = en | (t != 7'd0);
  assign mode_eff = (t == 7'd0) ? sha_type[1] : mode64;
  assign last_t   = mode64 ? 7'(BLOCK1024_WORDS - 1) : 7'(BLOCK512_WORDS - 1);
  assign in_word  = mode_eff ? 64'(s_axis_tdata) : {32'h0, s_axis_tdata[31:0]};

  w_scheduler_small_sigma u_sigma0 (
    .mode64 (mode64),
    .sel    (1'b0),
    .data   (win[1]),
    .result (s0_out)
  );

  w_scheduler_small_sigma u_sigma1 (
    .mode64 (mode64),
    .sel    (1'b1),
    .data   (win[14]),
    .result (s1_out)
  );

  assign expand_word = madd_32_64(mode64, s1_out, win[9], s0_out, win[0]);
  assign shift_word  = (state == ST_LOAD) ? in_word : expand_word;

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = M_AXIS_DATA_WIDTH'(shift_word);
    if (axi_resetn) begin
      if (state == ST_LOAD) begin
        s_axis_tready = m_axis_tready & go;
        m_axis_tvalid = s_axis_tvalid & go;
      end else begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (t == last_t);
      end
    end
  end

  assign hs_in  = s_axis_tvalid & s_axis_tready;
  assign hs_exp = (state == ST_EXPAND) & m_axis_tvalid & m_axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state     <= ST_LOAD;
      t         <= 7'd0;
      mode64    <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        win[i] <= '0;
      end
    end else begin
      proto_err <= 1'b0;
      if (hs_in || hs_exp) begin
        for (int i = 0; i < MSG_WORDS - 1; i++) begin
          win[i] <= win[i + 1];
        end
        win[MSG_WORDS - 1] <= shift_word;
      end
      if (hs_in) begin
        if (t == 7'd0) begin
          mode64 <= sha_type[1];
        end
        // tlast is only checked; word counting carries on regardless.
        proto_err <= s_axis_tlast ^ (t == 7'(MSG_WORDS - 1));
        if (t == 7'(MSG_WORDS - 1)) begin
          state <= ST_EXPAND;
        end
        t <= t + 7'd1;
      end else if (hs_exp) begin
        if (t == last_t) begin
          state <= ST_LOAD;
          t     <= 7'd0;
        end else begin
          t <= t + 7'd1;
        end
      end
    end
  end

endmodule
